// File: rtl/spi_mitm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_mitm_pkg
// Description : Shared definitions for the SPI man-in-the-middle sequencer:
//               FSM state encoding, substitution counter width and a
//               saturating increment helper.
//               Optional feature macro (used by the sequencer):
//               SPI_MITM_MISO_SUBST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_mitm_pkg;

    localparam int c_cnt_w = 16;

    typedef logic [2:0] state_t;

    localparam logic [2:0] c_st_passive   = 3'd0;
    localparam logic [2:0] c_st_idle      = 3'd1;
    localparam logic [2:0] c_st_fwd_wait  = 3'd2;
    localparam logic [2:0] c_st_fwd_start = 3'd3;
    localparam logic [2:0] c_st_miso_wait = 3'd4;
    localparam logic [2:0] c_st_ret_wait  = 3'd5;
    localparam logic [2:0] c_st_ret_start = 3'd6;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] v);
        return (v == {c_cnt_w{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_mitm_keepalive_timer.sv
`default_nettype none
// ============================================================================
// Module      : spi_mitm_keepalive_timer
// Description : Idle down-counter that keeps the slave-side chip select
//               asserted between forwarded words.
//   clk          in  system clock (rising edge)
//   rst          in  synchronous active-high reset
//   i_load       in  reload to KEEPALIVE_CYCLES (word start on slave side)
//   i_tick       in  count one idle cycle
//   i_clear      in  force counter and output to zero (passive mode)
//   o_keep_alive out keep-alive request
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mitm_keepalive_timer #(
    parameter int KEEPALIVE_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_tick,
    input  logic i_clear,
    output logic o_keep_alive
);

    localparam int             c_w      = $clog2(KEEPALIVE_CYCLES + 1);
    localparam logic [c_w-1:0] c_reload = c_w'(KEEPALIVE_CYCLES);

    logic [c_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_reload;
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // The load term raises keep-alive in the start cycle itself, before the
    // reloaded count becomes visible.
    assign o_keep_alive = !i_clear && (i_load || (r_cnt != '0));

endmodule
`default_nettype wire

// File: rtl/spi_mitm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_mitm_sequencer
// Description : Sits between a real SPI master (if0) and a real slave (if1).
//               In MITM mode each master word is captured, optionally
//               substituted, forwarded to the slave; the slave's reply is
//               captured (optionally substituted) and handed to the
//               master-side driver, which returns it on the next word.
//               Macro SPI_MITM_MISO_SUBST_EN compiles in MISO substitution.
// Ports:
//   sys_clk, rst                     clock / sync active-high reset
//   mitm_en                          request MITM mode (sampled in IDLE)
//   mosi_match/replace               MOSI substitution pair
//   miso_match/replace               MISO substitution pair
//   subst_count                      saturating substituted-word count
//   fake_if0_miso_select/start/data  master-side fake driver control
//   fake_if1_mosi_select/start/data  slave-side fake driver control
//   fake_if1_keep_alive              hold slave SS between words
//   if0_mosi_new_data_ready, real_if0_mosi_data   word from master
//   if1_miso_new_data_ready, real_if1_miso_data   word from slave
//   if0_miso_send_ready, if1_mosi_send_ready      driver ready flags
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mitm_sequencer
    import spi_mitm_pkg::*;
#(
    parameter int NUM_DATA_BITS    = 8,
    parameter int KEEPALIVE_CYCLES = 64
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     mitm_en,
    input  logic [NUM_DATA_BITS-1:0] mosi_match,
    input  logic [NUM_DATA_BITS-1:0] mosi_replace,
    input  logic [NUM_DATA_BITS-1:0] miso_match,
    input  logic [NUM_DATA_BITS-1:0] miso_replace,
    output logic [c_cnt_w-1:0]       subst_count,
    output logic                     fake_if0_miso_select,
    output logic                     fake_if1_mosi_select,
    output logic                     fake_if0_miso_start,
    output logic                     fake_if1_mosi_start,
    output logic                     fake_if1_keep_alive,
    output logic [NUM_DATA_BITS-1:0] fake_if0_miso_data,
    output logic [NUM_DATA_BITS-1:0] fake_if1_mosi_data,
    input  logic                     if0_mosi_new_data_ready,
    input  logic                     if1_miso_new_data_ready,
    input  logic                     if0_miso_send_ready,
    input  logic                     if1_mosi_send_ready,
    input  logic [NUM_DATA_BITS-1:0] real_if0_mosi_data,
    input  logic [NUM_DATA_BITS-1:0] real_if1_miso_data
);

    state_t                   r_state;
    state_t                   w_next;
    logic                     w_take_mosi;
    logic                     w_take_miso;
    logic                     w_mosi_hit;
    logic                     w_miso_hit;
    logic [NUM_DATA_BITS-1:0] w_mosi_word;
    logic [NUM_DATA_BITS-1:0] w_miso_word;
    logic [NUM_DATA_BITS-1:0] r_mosi_data;
    logic [NUM_DATA_BITS-1:0] r_miso_data;
    logic [c_cnt_w-1:0]       r_subst_count;

    assign w_mosi_hit  = (real_if0_mosi_data == mosi_match);
    assign w_mosi_word = w_mosi_hit ? mosi_replace : real_if0_mosi_data;

`ifdef SPI_MITM_MISO_SUBST_EN
    assign w_miso_hit  = (real_if1_miso_data == miso_match);
    assign w_miso_word = w_miso_hit ? miso_replace : real_if1_miso_data;
`else
    // MISO passes through untouched; the match/replace ports are parked.
    logic w_unused_miso;
    assign w_unused_miso = ^{miso_match, miso_replace};
    assign w_miso_hit    = 1'b0;
    assign w_miso_word   = real_if1_miso_data;
`endif

    // A master word is only accepted while IDLE and still enabled; pulses in
    // any other state are dropped, never queued.
    assign w_take_mosi = (r_state == c_st_idle) && mitm_en && if0_mosi_new_data_ready;
    assign w_take_miso = (r_state == c_st_miso_wait) && if1_miso_new_data_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_passive:   if (mitm_en) w_next = c_st_idle;
            c_st_idle: begin
                if (!mitm_en)                     w_next = c_st_passive;
                else if (if0_mosi_new_data_ready) w_next = c_st_fwd_wait;
            end
            c_st_fwd_wait:  if (if1_mosi_send_ready) w_next = c_st_fwd_start;
            c_st_fwd_start: w_next = c_st_miso_wait;
            c_st_miso_wait: if (if1_miso_new_data_ready) w_next = c_st_ret_wait;
            c_st_ret_wait:  if (if0_miso_send_ready) w_next = c_st_ret_start;
            c_st_ret_start: w_next = c_st_idle;
            default:        w_next = c_st_passive;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state       <= c_st_passive;
            r_mosi_data   <= '0;
            r_miso_data   <= '0;
            r_subst_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_take_mosi) r_mosi_data <= w_mosi_word;
            if (w_take_miso) r_miso_data <= w_miso_word;
            // MOSI and MISO captures live in different states, so at most
            // one increment per cycle.
            if ((w_take_mosi && w_mosi_hit) || (w_take_miso && w_miso_hit))
                r_subst_count <= sat_inc(r_subst_count);
        end
    end

    spi_mitm_keepalive_timer #(
        .KEEPALIVE_CYCLES (KEEPALIVE_CYCLES)
    ) u_keepalive (
        .clk          (sys_clk),
        .rst          (rst),
        .i_load       (r_state == c_st_fwd_start),
        .i_tick       (r_state == c_st_idle),
        .i_clear      (r_state == c_st_passive),
        .o_keep_alive (fake_if1_keep_alive)
    );

    assign fake_if0_miso_select = (r_state != c_st_passive);
    assign fake_if1_mosi_select = (r_state != c_st_passive);
    assign fake_if1_mosi_start  = (r_state == c_st_fwd_start);
    assign fake_if0_miso_start  = (r_state == c_st_ret_start);
    assign fake_if1_mosi_data   = r_mosi_data;
    assign fake_if0_miso_data   = r_miso_data;
    assign subst_count          = r_subst_count;

endmodule
`default_nettype wire
